// File: rtl/tlb_ctrl.sv
// Sequencing controller for a set-associative TLB: tag lookup with LRU bump,
// page-table-walk refill on a miss, and a full-array flush.
module tlb_ctrl #(
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 4,
  parameter int SET_INDEX_BITS = 4,
  parameter int LRU_BITS       = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [31:0]                       req_vaddr_i,
  input  logic                              req_is_write_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output logic [19:0]                       resp_ppn_o,
  output logic                              resp_hit_o,
  output logic                              resp_fault_o,
  output logic                              ptw_req_valid_o,
  input  logic                              ptw_req_ready_i,
  output logic [19:0]                       ptw_req_vpn_o,
  input  logic                              ptw_resp_valid_i,
  input  logic [19:0]                       ptw_resp_ppn_i,
  input  logic [1:0]                        ptw_resp_perms_i,
  input  logic                              ptw_resp_fault_i,
  input  logic                              flush_req_i,
  output logic                              flush_busy_o,
  output logic [SET_INDEX_BITS-1:0]         rd_set_index_o,
  input  logic [NUM_WAYS-1:0]               rd_valid_i,
  input  logic [NUM_WAYS-1:0][19:0]         rd_vpn_i,
  input  logic [NUM_WAYS-1:0][19:0]         rd_ppn_i,
  input  logic [NUM_WAYS-1:0][1:0]          rd_perms_i,
  input  logic [NUM_WAYS-1:0][LRU_BITS-1:0] rd_lru_count_i,
  output logic                              wr_en_o,
  output logic [SET_INDEX_BITS-1:0]         wr_set_index_o,
  output logic [1:0]                        wr_way_o,
  output logic                              wr_valid_o,
  output logic [19:0]                       wr_vpn_o,
  output logic [19:0]                       wr_ppn_o,
  output logic [1:0]                        wr_perms_o,
  output logic [LRU_BITS-1:0]               wr_lru_count_o,
  output logic                              lru_update_en_o,
  output logic [SET_INDEX_BITS-1:0]         lru_set_index_o,
  output logic [1:0]                        lru_way_o,
  output logic [LRU_BITS-1:0]               lru_value_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOOKUP = 3'd1, PTW_REQ = 3'd2, PTW_WAIT = 3'd3,
    FILL = 3'd4, RESP = 3'd5, FLUSH = 3'd6
  } state_e;

  state_e                    state_q, state_d;
  logic [19:0]               vpn_q, ppn_q;
  logic [1:0]                perms_q, victim_q;
  logic                      is_write_q, hit_q, fault_q;
  logic [SET_INDEX_BITS-1:0] flush_set_q;
  logic [1:0]                flush_way_q;

  logic [SET_INDEX_BITS-1:0] set_s;
  logic                      hit_s, inv_found_s, flush_last_s;
  logic [1:0]                hit_way_s, inv_way_s, lru_way_s, victim_s;
  logic [LRU_BITS-1:0]       min_cnt_s;
  logic                      unused_s;

  function automatic logic perm_fault(input logic is_write, input logic [1:0] perms);
    return is_write ? !perms[1] : !perms[0];
  endfunction

  assign set_s          = vpn_q[SET_INDEX_BITS-1:0];
  assign rd_set_index_o = set_s;
  assign lru_value_o    = {LRU_BITS{1'b0}};
  assign unused_s       = ^req_vaddr_i[11:0];
  assign flush_last_s   = (flush_set_q == SET_INDEX_BITS'(NUM_SETS - 1)) &&
                          (flush_way_q == 2'(NUM_WAYS - 1));

  // Hit way is the lowest matching way; victim prefers the lowest invalid way,
  // then the lowest-index way holding the minimum usage count.
  always_comb begin
    hit_s       = 1'b0;
    hit_way_s   = 2'd0;
    inv_found_s = 1'b0;
    inv_way_s   = 2'd0;
    lru_way_s   = 2'd0;
    min_cnt_s   = rd_lru_count_i[0];
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_way_s   = (!hit_s && rd_valid_i[w] && (rd_vpn_i[w] == vpn_q)) ? 2'(w) : hit_way_s;
      hit_s       = hit_s || (rd_valid_i[w] && (rd_vpn_i[w] == vpn_q));
      inv_way_s   = (!inv_found_s && !rd_valid_i[w]) ? 2'(w) : inv_way_s;
      inv_found_s = inv_found_s || !rd_valid_i[w];
      lru_way_s   = (rd_lru_count_i[w] < min_cnt_s) ? 2'(w) : lru_way_s;
      min_cnt_s   = (rd_lru_count_i[w] < min_cnt_s) ? rd_lru_count_i[w] : min_cnt_s;
    end
    victim_s = inv_found_s ? inv_way_s : lru_way_s;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Flush has priority in IDLE and is only observed there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (flush_req_i) state_d = FLUSH;
                else if (req_valid_i) state_d = LOOKUP;
                else state_d = IDLE;
      LOOKUP:   state_d = hit_s ? RESP : PTW_REQ;
      PTW_REQ:  state_d = ptw_req_ready_i ? PTW_WAIT : PTW_REQ;
      PTW_WAIT: if (ptw_resp_valid_i) state_d = ptw_resp_fault_i ? RESP : FILL;
                else state_d = PTW_WAIT;
      FILL:     state_d = RESP;
      RESP:     state_d = resp_ready_i ? IDLE : RESP;
      FLUSH:    state_d = flush_last_s ? IDLE : FLUSH;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vpn_q <= 20'd0; ppn_q <= 20'd0; perms_q <= 2'd0; victim_q <= 2'd0;
      is_write_q <= 1'b0; hit_q <= 1'b0; fault_q <= 1'b0;
      flush_set_q <= {SET_INDEX_BITS{1'b0}}; flush_way_q <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          flush_set_q <= {SET_INDEX_BITS{1'b0}};
          flush_way_q <= 2'd0;
          if (req_valid_i && req_ready_o) begin
            vpn_q      <= req_vaddr_i[31:12];
            is_write_q <= req_is_write_i;
            hit_q      <= 1'b0;
            fault_q    <= 1'b0;
            ppn_q      <= 20'd0;
          end else begin
            vpn_q <= vpn_q;
          end
        end
        LOOKUP: begin
          victim_q <= victim_s;
          if (hit_s) begin
            ppn_q   <= rd_ppn_i[hit_way_s];
            perms_q <= rd_perms_i[hit_way_s];
            hit_q   <= 1'b1;
            fault_q <= perm_fault(is_write_q, rd_perms_i[hit_way_s]);
          end else begin
            hit_q <= 1'b0;
          end
        end
        PTW_WAIT: begin
          if (ptw_resp_valid_i && ptw_resp_fault_i) begin
            ppn_q <= 20'd0; perms_q <= 2'd0; fault_q <= 1'b1;
          end else if (ptw_resp_valid_i) begin
            ppn_q   <= ptw_resp_ppn_i;
            perms_q <= ptw_resp_perms_i;
            fault_q <= perm_fault(is_write_q, ptw_resp_perms_i);
          end else begin
            ppn_q <= ppn_q;
          end
        end
        FLUSH: begin
          if (flush_way_q == 2'(NUM_WAYS - 1)) begin
            flush_way_q <= 2'd0;
            flush_set_q <= flush_set_q + SET_INDEX_BITS'(1);
          end else begin
            flush_way_q <= flush_way_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state so every one of them is 0 while in reset.
  always_comb begin
    req_ready_o = 1'b0; resp_valid_o = 1'b0; resp_ppn_o = 20'd0; resp_hit_o = 1'b0;
    resp_fault_o = 1'b0; ptw_req_valid_o = 1'b0; ptw_req_vpn_o = 20'd0; flush_busy_o = 1'b0;
    wr_en_o = 1'b0; wr_set_index_o = {SET_INDEX_BITS{1'b0}}; wr_way_o = 2'd0; wr_valid_o = 1'b0;
    wr_vpn_o = 20'd0; wr_ppn_o = 20'd0; wr_perms_o = 2'd0; wr_lru_count_o = {LRU_BITS{1'b0}};
    lru_update_en_o = 1'b0; lru_set_index_o = {SET_INDEX_BITS{1'b0}}; lru_way_o = 2'd0;
    case (state_q)
      IDLE:   req_ready_o = !flush_req_i && !rst_i;
      LOOKUP: begin
        if (hit_s && (rd_lru_count_i[hit_way_s] != {LRU_BITS{1'b1}})) begin
          lru_update_en_o = 1'b1;
          lru_set_index_o = set_s;
          lru_way_o       = hit_way_s;
        end else begin
          lru_update_en_o = 1'b0;
        end
      end
      PTW_REQ: begin
        ptw_req_valid_o = 1'b1;
        ptw_req_vpn_o   = vpn_q;
      end
      PTW_WAIT: ;
      FILL: begin
        wr_en_o = 1'b1; wr_set_index_o = set_s; wr_way_o = victim_q; wr_valid_o = 1'b1;
        wr_vpn_o = vpn_q; wr_ppn_o = ppn_q; wr_perms_o = perms_q;
        wr_lru_count_o = LRU_BITS'(1);
      end
      RESP: begin
        resp_valid_o = 1'b1; resp_ppn_o = ppn_q; resp_hit_o = hit_q; resp_fault_o = fault_q;
      end
      FLUSH: begin
        flush_busy_o = 1'b1; wr_en_o = 1'b1;
        wr_set_index_o = flush_set_q; wr_way_o = flush_way_q;
      end
      default: ;
    endcase
  end

endmodule
